// File: rtl/pulse_width_meter.sv
// Measures the high time of pulse_in after arm, in units of PRESCALE cycles, with a
// saturating count and overflow flag. Define PULSE_METER_SYNC_EN to add a 2-flop input synchronizer.
module pulse_width_meter #(
   parameter int PRESCALE = 4,
   parameter int COUNT_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               pulse_in,
   output logic [COUNT_W-1:0] count_out,
   output logic               overflow,
   output logic               valid,
   input  logic               ready,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOW  = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]      PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

   state_t          state, state_nxt;
   logic [PW-1:0]   pre_q;
   logic            s, s_d, rise, fall;

`ifdef PULSE_METER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], pulse_in};
   end

   assign s = sync_q[1];
`else
   assign s = pulse_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) s_d <= 1'b0;
      else     s_d <= s;
   end

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (arm)   state_nxt = s ? WAIT_LOW : WAIT_RISE;
         WAIT_LOW:  if (!s)    state_nxt = WAIT_RISE;
         WAIT_RISE: if (rise)  state_nxt = MEASURE;
         MEASURE:   if (fall)  state_nxt = DONE;
         DONE:      if (ready) state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // The rising-edge cycle is already high cycle 1, so the prescaler starts one step in.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q     <= '0;
         count_out <= '0;
         overflow  <= 1'b0;
      end else if (state == WAIT_RISE && rise) begin
         overflow <= 1'b0;
         if (PRESCALE == 1) begin
            pre_q     <= '0;
            count_out <= COUNT_W'(1);
         end else begin
            pre_q     <= PW'(1);
            count_out <= '0;
         end
      end else if (state == MEASURE && s) begin
         if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            if (count_out == CNT_MAX) overflow  <= 1'b1;
            else                      count_out <= count_out + COUNT_W'(1);
         end else begin
            pre_q <= pre_q + PW'(1);
         end
      end
   end

   assign valid = (state == DONE);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Randomized pulse-width bench: each measurement's result is predicted from the pulse length
// alone (floor division, saturation, overflow threshold) and checked at the handshake.
module tb_pulse_width_meter;

   localparam int P  = 4;
   localparam int CW = 4;
`ifdef PULSE_METER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst, arm, pulse_in, ready;
   logic [CW-1:0] count_out;
   logic          overflow, valid, busy;

   logic [CW:0]   exp_q[$];
   logic [CW:0]   mon_e;
   int            n_vec = 0;
   int            n_err = 0;

   pulse_width_meter #(.PRESCALE(P), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in),
      .count_out(count_out), .overflow(overflow), .valid(valid),
      .ready(ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference: a high time of h cycles yields floor(h/P) units, saturating, with overflow at P*2^CW.
   function automatic logic [CW:0] model(input int h);
      int q;
      q = h / P;
      if (q > (1 << CW) - 1) q = (1 << CW) - 1;
      return {(h >= P * (1 << CW)), CW'(q)};
   endfunction

   // Scoreboard: every completed handshake must match the oldest predicted result.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("count", 32'(count_out), 32'(mon_e[CW-1:0]));
            check("overflow", 32'(overflow), 32'(mon_e[CW]));
         end
      end
   end

   task automatic measure(input int h, input int rdy_delay);
      logic [CW:0] e;
      e = model(h);
      ready = (rdy_delay == 0);
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      check("busy_after_arm", 32'(busy), 32'd1);
      step(3);
      pulse_in = 1'b1;
      step(h);
      pulse_in = 1'b0;
      exp_q.push_back(e);
      step(LAT);
      check("valid_early", 32'(valid), 32'd0);
      step(1);
      check("valid_latency", 32'(valid), 32'd1);
      for (int i = 0; i < rdy_delay; i++) begin
         arm = 1'($urandom_range(0, 1));
         step(1);
         check("hold_valid", 32'(valid), 32'd1);
         check("hold_busy", 32'(busy), 32'd1);
         check("hold_count", 32'(count_out), 32'(e[CW-1:0]));
      end
      arm = 1'b0;
      ready = 1'b1;
      step(1);
      check("valid_drop", 32'(valid), 32'd0);
      check("busy_drop", 32'(busy), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, d;
      rst = 1'b1; arm = 1'b0; pulse_in = 1'b0; ready = 1'b1;
      step(2);
      check("rst_count", 32'(count_out), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step(3);

      // Basic and saturation boundaries.
      measure(20, 0);
      measure(63, 0);
      measure(64, 0);
      measure(200, 0);
      measure(3, 0);
      measure(4, 0);

      // Armed while the pulse is already high: only the following pulse is measured.
      pulse_in = 1'b1;
      step(4);
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      step(4);
      pulse_in = 1'b0;
      step(4);
      check("whilehigh_busy", 32'(busy), 32'd1);
      check("whilehigh_valid", 32'(valid), 32'd0);
      exp_q.push_back(model(8));
      pulse_in = 1'b1;
      step(8);
      pulse_in = 1'b0;
      step(LAT + 1);
      check("whilehigh_valid_late", 32'(valid), 32'd1);
      step(1);
      check("whilehigh_idle", 32'(busy), 32'd0);

      // Back-pressure with arm pulses that must be ignored.
      measure(37, 10);

      // Reset in the middle of a measurement.
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      step(3);
      pulse_in = 1'b1;
      step(10);
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      pulse_in = 1'b0;
      step(1);
      rst = 1'b0;
      check("midrst_count", 32'(count_out), 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      step(3);
      measure(12, 0);

      // Randomized pulse widths and consumer delays.
      for (int k = 0; k < 25; k++) begin
         h = $urandom_range(3, 90);
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         measure(h, d);
      end

      step(2);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
